error_conv_check: RTL

//  Parametrised FastICA convergence checker; successor to the fixed 4x4 error calculator.

---
 rtl/error_conv_check.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/error_conv_check.sv
// FastICA convergence checker: streams w_new (N*N elements, row-major), compares each element against stored w_ica, keeps the max error.
// Latency: conv_done pulses the cycle after the N*N-th accepted element; rd_data has a 1-cycle registered read latency.
// Backpressure: in_ready is high only in ACC, so in_valid gaps stall the pass; in_valid is ignored outside ACC.
//
// Ports: clk_conv/rst_conv (async active-high), en_conv/iter_clr (pass control, IDLE only),
//   in_valid/in_ready/in_data (element stream), rd_addr/rd_data (stored matrix readback),
//   conv_busy, conv_done, isConverge, timeout, iter_cnt (status).
// Optional feature macro CONV_MAXERR_EN: adds output max_err_o (max error of the last pass).
module error_conv_check #(
    parameter int            N        = 4,
    parameter int            W        = 26,
    parameter logic [W-1:0]  TOL      = 26'd64,
    parameter int            MAX_ITER = 255,
    parameter int            IW       = 8,
    localparam int           NN       = N * N,
    localparam int           AW       = (NN > 1) ? $clog2(NN) : 1
) (
    input  logic                 clk_conv,
    input  logic                 rst_conv,
    input  logic                 en_conv,
    input  logic                 iter_clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W-1:0]  in_data,
    input  logic [AW-1:0]        rd_addr,
    output logic signed [W-1:0]  rd_data,
    output logic                 conv_busy,
    output logic                 conv_done,
    output logic                 isConverge,
    output logic                 timeout,
    output logic [IW-1:0]        iter_cnt
`ifdef CONV_MAXERR_EN
    ,
    output logic [W-1:0]         max_err_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_CMP  = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [AW-1:0]        idx;
    logic [W-1:0]         max_err;
    logic signed [W-1:0]  w_ica [NN];

    logic                 accept;
    logic                 last_elem;
    logic [W-1:0]         abs_new, abs_old;
    logic [W:0]           diff, diff_neg;
    logic [W-1:0]         err;
    logic                 conv_now;
    logic [IW:0]          iter_inc;
    logic                 iter_limit;

    // Magnitude with the most-negative value clamped, so the result always fits W-1 bits.
    function automatic logic [W-1:0] abs_sat(input logic signed [W-1:0] x);
        logic [W-1:0] r;
        if (x == {1'b1, {(W-1){1'b0}}})
            r = {1'b0, {(W-1){1'b1}}};
        else if (x[W-1])
            r = W'(-x);
        else
            r = x;
        return r;
    endfunction

    assign accept    = in_valid && (state == S_ACC);
    assign last_elem = (idx == AW'(NN - 1));

    // Both magnitudes are < 2^(W-1), so a W+1 bit difference cannot overflow and
    // its absolute value fits in W unsigned bits.
    always_comb begin
        abs_new  = abs_sat(in_data);
        abs_old  = abs_sat(w_ica[idx]);
        diff     = {1'b0, abs_new} - {1'b0, abs_old};
        diff_neg = -diff;
        err      = diff[W] ? diff_neg[W-1:0] : diff[W-1:0];
    end

    // First pass compares against a cleared matrix, so it never counts as converged.
    assign conv_now   = (max_err <= TOL) && (iter_cnt != '0);
    assign iter_inc   = {1'b0, iter_cnt} + 1'b1;
    assign iter_limit = (iter_inc >= (IW+1)'(MAX_ITER));

    // FSM: state register
    always_ff @(posedge clk_conv or posedge rst_conv) begin
        if (rst_conv)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (en_conv && !iter_clr) state_nxt = S_ACC;
            S_ACC:  if (accept && last_elem)  state_nxt = S_CMP;
            S_CMP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = 1'b0;
        conv_busy = 1'b0;
        conv_done = 1'b0;
        case (state)
            S_ACC: begin
                in_ready  = 1'b1;
                conv_busy = 1'b1;
            end
            S_CMP: begin
                conv_busy = 1'b1;
                conv_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: element counter, max error, stored matrix, pass results
    always_ff @(posedge clk_conv or posedge rst_conv) begin
        if (rst_conv) begin
            idx        <= '0;
            max_err    <= '0;
            iter_cnt   <= '0;
            isConverge <= 1'b0;
            timeout    <= 1'b0;
            for (int i = 0; i < NN; i++)
                w_ica[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iter_clr) begin
                        iter_cnt   <= '0;
                        isConverge <= 1'b0;
                        timeout    <= 1'b0;
                        for (int i = 0; i < NN; i++)
                            w_ica[i] <= '0;
                    end else if (en_conv) begin
                        max_err <= '0;
                        idx     <= '0;
                    end
                end
                S_ACC: begin
                    if (accept) begin
                        // err was formed from the old w_ica[idx]; overwrite on the same edge.
                        w_ica[idx] <= in_data;
                        if (err > max_err)
                            max_err <= err;
                        idx <= last_elem ? '0 : idx + 1'b1;
                    end
                end
                S_CMP: begin
                    if (iter_cnt < IW'(MAX_ITER))
                        iter_cnt <= iter_inc[IW-1:0];
                    isConverge <= conv_now;
                    timeout    <= !conv_now && iter_limit;
                end
                default: ;
            endcase
        end
    end

    // Registered readback; a same-cycle write is not bypassed, so the old value is returned.
    always_ff @(posedge clk_conv or posedge rst_conv) begin
        if (rst_conv)
            rd_data <= '0;
        else
            rd_data <= w_ica[rd_addr];
    end

`ifdef CONV_MAXERR_EN
    always_ff @(posedge clk_conv or posedge rst_conv) begin
        if (rst_conv)
            max_err_o <= '0;
        else if (state == S_CMP)
            max_err_o <= max_err;
    end
`endif

endmodule
